// File: rtl/scan_result_pkg.sv
// Shared constants, FSM encoding and output word payload for the scan_result block.
package scan_result_pkg;

  localparam int unsigned NUM_CH = 6;
  localparam int unsigned CH_W   = 3;
  localparam int unsigned DATA_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  typedef struct packed {
    logic [CH_W-1:0]   sel;
    logic [DATA_W-1:0] data;
  } word_t;

endpackage

// File: rtl/scan_result_next_ch_pick.sv
// Combinational picker: lowest set mask bit strictly above cur_idx, or the lowest
// set bit overall when from_bottom is set; none_left_c flags that nothing qualifies.
module next_ch_pick
  import scan_result_pkg::*;
(
  input  logic [NUM_CH-1:0] mask,
  input  logic [CH_W-1:0]   cur_idx,
  input  logic              from_bottom,
  output logic [CH_W-1:0]   nxt_idx_c,
  output logic              none_left_c
);

  always_comb begin
    nxt_idx_c   = '0;
    none_left_c = 1'b1;
    for (int i = 0; i < int'(NUM_CH); i++) begin
      if (none_left_c && mask[i] && (from_bottom || (CH_W'(i) > cur_idx))) begin
        nxt_idx_c   = CH_W'(i);
        none_left_c = 1'b0;
      end
    end
  end

endmodule

// File: rtl/scan_result.sv
// Snapshots NUM_CH source words and streams the masked channels out in ascending
// order under a valid/ready handshake, then pulses done.
module scan_result #(
  parameter int unsigned NUM_CH = 6
) (
  input  logic                               clk_sys,
  input  logic                               rst_sys_n,
  input  logic                               start,
  input  logic [NUM_CH-1:0]                  chan_mask,
  input  logic [scan_result_pkg::DATA_W-1:0] src0,
  input  logic [scan_result_pkg::DATA_W-1:0] src1,
  input  logic [scan_result_pkg::DATA_W-1:0] src2,
  input  logic [scan_result_pkg::DATA_W-1:0] src3,
  input  logic [scan_result_pkg::DATA_W-1:0] src4,
  input  logic [scan_result_pkg::DATA_W-1:0] src5,
  input  logic                               out_rdy,
  output logic                               data_en,
  output logic [scan_result_pkg::CH_W-1:0]   data_sel,
  output logic [scan_result_pkg::DATA_W-1:0] data_out,
  output logic                               busy,
  output logic                               done,
  output logic                               err_start
);

  import scan_result_pkg::*;

  logic [DATA_W-1:0] src_arr     [NUM_CH];
  logic [DATA_W-1:0] snap_data_q [NUM_CH];
  logic [NUM_CH-1:0] snap_mask_q;
  logic              snap_load;

  state_t state_q, state_d;
  word_t  word_q, word_d;
  logic   data_en_q, data_en_d;
  logic   busy_q, busy_d;
  logic   done_q, done_d;
  logic   err_q, err_d;

  logic [NUM_CH-1:0] pick_mask;
  logic [CH_W-1:0]   pick_idx;
  logic              pick_none;

  assign src_arr[0] = src0;
  assign src_arr[1] = src1;
  assign src_arr[2] = src2;
  assign src_arr[3] = src3;
  assign src_arr[4] = src4;
  assign src_arr[5] = src5;

  // In IDLE the first channel comes from the live mask, since the snapshot loads on the same edge.
  assign pick_mask = (state_q == ST_IDLE) ? chan_mask : snap_mask_q;

  next_ch_pick u_pick (
    .mask        (pick_mask),
    .cur_idx     (word_q.sel),
    .from_bottom (state_q == ST_IDLE),
    .nxt_idx_c   (pick_idx),
    .none_left_c (pick_none)
  );

  always_comb begin
    state_d   = state_q;
    word_d    = word_q;
    data_en_d = data_en_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    err_d     = 1'b0;
    snap_load = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          snap_load = 1'b1;
          if (pick_none) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
          end else begin
            state_d     = ST_SEND;
            busy_d      = 1'b1;
            data_en_d   = 1'b1;
            word_d.sel  = pick_idx;
            word_d.data = src_arr[pick_idx];
          end
        end
      end
      ST_SEND: begin
        err_d = start;
        if (out_rdy) begin
          if (pick_none) begin
            state_d   = ST_DONE;
            data_en_d = 1'b0;
            busy_d    = 1'b0;
            done_d    = 1'b1;
            word_d    = '0;
          end else begin
            word_d.sel  = pick_idx;
            word_d.data = snap_data_q[pick_idx];
          end
        end
      end
      ST_DONE: begin
        err_d   = start;
        state_d = ST_IDLE;
      end
      default: begin
        state_d   = ST_IDLE;
        word_d    = '0;
        data_en_d = 1'b0;
        busy_d    = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_sys or negedge rst_sys_n) begin
    if (!rst_sys_n) begin
      state_q   <= ST_IDLE;
      word_q    <= '0;
      data_en_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      word_q    <= word_d;
      data_en_q <= data_en_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  // Snapshot registers hold the scan's view of sources and mask until the next accepted start.
  always_ff @(posedge clk_sys or negedge rst_sys_n) begin
    if (!rst_sys_n) begin
      snap_mask_q <= '0;
      for (int i = 0; i < int'(NUM_CH); i++) snap_data_q[i] <= '0;
    end else if (snap_load) begin
      snap_mask_q <= chan_mask;
      for (int i = 0; i < int'(NUM_CH); i++) snap_data_q[i] <= src_arr[i];
    end
  end

  assign data_en   = data_en_q;
  assign data_sel  = word_q.sel;
  assign data_out  = word_q.data;
  assign busy      = busy_q;
  assign done      = done_q;
  assign err_start = err_q;

endmodule
